// File: rtl/regwrite_queue_if.sv
// Register-file write port bundle driven by regwrite_queue.
// DATA_WIDTH / NUM_REG come from global macros; defaults apply when undefined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef NUM_REG
`define NUM_REG 32
`endif

interface writeport;
    logic                         enable;
    logic [$clog2(`NUM_REG)-1:0]  addr;
    logic [`DATA_WIDTH-1:0]       data;

    modport writer (output enable, output addr, output data);
    modport reader (input  enable, input  addr, input  data);
    modport master (output enable, output addr, output data);
    modport slave  (input  enable, input  addr, input  data);
endinterface

// File: rtl/regwrite_queue.sv
// In-order register-file write buffer draining one entry per cycle onto writeport.
// Optional youngest-match lookup bypass compiled in with REGWRITE_BYPASS_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef NUM_REG
`define NUM_REG 32
`endif

module regwrite_queue #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [$clog2(`NUM_REG)-1:0]  in_addr,
    input  logic [`DATA_WIDTH-1:0]       in_data,
    input  logic                         hold,
    writeport.writer                     wp,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         empty
`ifdef REGWRITE_BYPASS_EN
    ,
    input  logic [$clog2(`NUM_REG)-1:0]  lk_addr,
    output logic                         lk_hit,
    output logic [`DATA_WIDTH-1:0]       lk_data
`endif
);

    localparam int AW = $clog2(`NUM_REG);
    localparam int DW = `DATA_WIDTH;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;

    assign in_ready = (count_q != CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign push     = in_valid && in_ready;
    assign pop      = !empty && !hold;

    assign wp.enable = pop;
    assign wp.addr   = addr_mem[head];
    assign wp.data   = data_mem[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is deliberately unreset; entries outside head..tail are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= in_addr;
            data_mem[tail] <= in_data;
        end
    end

`ifdef REGWRITE_BYPASS_EN
    logic          hit;
    logic [DW-1:0] hit_data;

    // Walk from head toward tail so a later match overrides: the youngest wins.
    always_comb begin
        logic [PW-1:0] idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count_q) && (addr_mem[idx] == lk_addr)) begin
                hit      = 1'b1;
                hit_data = data_mem[idx];
            end
        end
    end

    assign lk_hit  = hit;
    assign lk_data = hit_data;
`endif

endmodule

// File: tb/tb_regwrite_queue.sv
// Scoreboard bench for regwrite_queue: accepted requests queue expected writes,
// a negedge monitor pops and compares every write the DUT presents.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef NUM_REG
`define NUM_REG 32
`endif

module tb_regwrite_queue;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(`NUM_REG);
    localparam int DW    = `DATA_WIDTH;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [AW-1:0]        in_addr = '0;
    logic [DW-1:0]        in_data = '0;
    logic                 hold = 1'b0;
    logic [$clog2(DEPTH):0] count;
    logic                 empty;
`ifdef REGWRITE_BYPASS_EN
    logic [AW-1:0]        lk_addr = '0;
    logic                 lk_hit;
    logic [DW-1:0]        lk_data;
`endif

    writeport wp_if ();

    regwrite_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .hold     (hold),
        .wp       (wp_if),
        .count    (count),
        .empty    (empty)
`ifdef REGWRITE_BYPASS_EN
        ,
        .lk_addr  (lk_addr),
        .lk_hit   (lk_hit),
        .lk_data  (lk_data)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [AW+DW-1:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change just after the edge; a request is expected to land iff in_ready is high now.
    task automatic step(input logic v, input int a, input int d, input logic h);
        @(posedge clk);
        #1;
        in_valid = v;
        in_addr  = AW'(a);
        in_data  = DW'(d);
        hold     = h;
        if (v && in_ready) sb.push_back({AW'(a), DW'(d)});
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic drain(input int cycles);
        repeat (cycles) step(1'b0, 0, 0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n && wp_if.enable) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write",
                         wp_if.addr, wp_if.data);
            end else begin
                logic [AW+DW-1:0] exp;
                exp = sb.pop_front();
                if ({wp_if.addr, wp_if.data} !== exp) begin
                    failures++;
                    $display("FAIL write_order: got addr=%0h data=%0h expected addr=%0h data=%0h",
                             wp_if.addr, wp_if.data, exp[AW+DW-1:DW], exp[DW-1:0]);
                end
            end
        end
    end

    initial begin
        #2;
        chk("rst_count",    32'(count),        0);
        chk("rst_empty",    32'(empty),        1);
        chk("rst_in_ready", 32'(in_ready),     1);
        chk("rst_enable",   32'(wp_if.enable), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single write: visible on the port the cycle after acceptance.
        step(1'b1, 3, 'hA5, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        settle();
        chk("lat_enable", 32'(wp_if.enable), 1);
        chk("lat_addr",   32'(wp_if.addr),   3);
        chk("lat_data",   32'(wp_if.data),   'hA5);
        step(1'b0, 0, 0, 1'b0);
        settle();
        chk("lat_empty", 32'(empty), 1);
        chk("lat_count", 32'(count), 0);

        // Fill under hold; fifth request refused.
        for (int i = 0; i < 4; i++) step(1'b1, 10 + i, 'h100 + i, 1'b1);
        step(1'b1, 20, 'hDEAD, 1'b1);
        settle();
        chk("full_count",    32'(count),        4);
        chk("full_in_ready", 32'(in_ready),     0);
        chk("full_hold_en",  32'(wp_if.enable), 0);
        step(1'b0, 0, 0, 1'b0);
        settle();
        chk("fifth_refused", 32'(count),        4);
        chk("drain_enable",  32'(wp_if.enable), 1);
        step(1'b0, 0, 0, 1'b0);
        settle();
        chk("after_drain_ready", 32'(in_ready), 1);
        chk("after_drain_count", 32'(count),    3);
        drain(4);
        settle();
        chk("fill_drained", 32'(empty), 1);

        // Full + drain in the same cycle still refuses; count goes 4,3,4.
        for (int i = 0; i < 4; i++) step(1'b1, 1 + i, 'h200 + i, 1'b1);
        step(1'b1, 17, 'h1234, 1'b0);
        settle();
        chk("seq_c0",     32'(count),    4);
        chk("seq_refuse", 32'(in_ready), 0);
        step(1'b1, 17, 'h1234, 1'b1);
        settle();
        chk("seq_c1",     32'(count),    3);
        chk("seq_accept", 32'(in_ready), 1);
        step(1'b0, 0, 0, 1'b0);
        settle();
        chk("seq_c2", 32'(count), 4);
        drain(5);

        // Sustained streaming with wrap: no gaps, occupancy never above 1.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i, i, 1'b0);
            settle();
            chk("stream_count_le1", 32'(count <= 1), 1);
            if (i > 0) chk("stream_no_gap", 32'(wp_if.enable), 1);
        end
        drain(3);
        settle();
        chk("stream_empty", 32'(empty), 1);

`ifdef REGWRITE_BYPASS_EN
        step(1'b1, 5, 1, 1'b1);
        step(1'b1, 2, 7, 1'b1);
        step(1'b1, 5, 9, 1'b1);
        step(1'b0, 0, 0, 1'b1);
        lk_addr = AW'(5);
        settle();
        chk("lk_hit_5",  32'(lk_hit),  1);
        chk("lk_data_5", 32'(lk_data), 9);
        lk_addr = AW'(2);
        settle();
        chk("lk_data_2", 32'(lk_data), 7);
        lk_addr = AW'(4);
        settle();
        chk("lk_hit_4",  32'(lk_hit),  0);
        chk("lk_data_4", 32'(lk_data), 0);
        drain(4);
`endif

        // Asynchronous reset while draining discards pending entries.
        for (int i = 0; i < 3; i++) step(1'b1, 7 + i, 'h300 + i, 1'b1);
        step(1'b0, 0, 0, 1'b0);
        settle();
        chk("mid_enable", 32'(wp_if.enable), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_enable",   32'(wp_if.enable), 0);
        chk("arst_count",    32'(count),        0);
        chk("arst_empty",    32'(empty),        1);
        chk("arst_in_ready", 32'(in_ready),     1);
`ifdef REGWRITE_BYPASS_EN
        chk("arst_lk_hit",   32'(lk_hit),       0);
`endif
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drain(6);
        settle();
        chk("post_rst_count", 32'(count), 0);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
